// File: rtl/vga_draw_scheduler.sv
// Arbitrates cursor/playhead cell redraws onto vga_display's single draw port, one draw at a time.
// Optional DRAW_STATS_EN adds saturating draw_count/drop_count outputs.
module vga_draw_scheduler #(
  parameter int X0            = 214,
  parameter int Y0            = 32,
  parameter int PITCH         = 33,
  parameter int GRID_MAX      = 11,
  parameter int IDLE_CYCLES   = 3,
  parameter int START_TIMEOUT = 8
) (
  input  logic       CLOCK_50,
  input  logic       nReset,
  input  logic       req0,
  input  logic [3:0] req0_col,
  input  logic [3:0] req0_row,
  input  logic [3:0] req0_old_col,
  input  logic [3:0] req0_old_row,
  input  logic       req0_state,
  output logic       ack0,
  input  logic       req1,
  input  logic [3:0] req1_col,
  input  logic [3:0] req1_row,
  input  logic [3:0] req1_old_col,
  input  logic [3:0] req1_old_row,
  input  logic       req1_state,
  output logic       ack1,
  input  logic       drawing,
  output logic       draw_enable,
  output logic [9:0] X,
  output logic [8:0] Y,
  output logic [9:0] OLD_X,
  output logic [8:0] OLD_Y,
  output logic       state,
  output logic       ready,
  output logic       err
`ifdef DRAW_STATS_EN
  ,
  output logic [15:0] draw_count,
  output logic [7:0]  drop_count
`endif
);

  localparam int ICW = $clog2(IDLE_CYCLES + 1);
  localparam int TCW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_INIT_BUSY, S_INIT_IDLE, S_READY, S_ISSUE, S_WAIT_START, S_WAIT_DONE
  } fsm_t;

  fsm_t           fsm_reg;
  logic           rr_reg;
  logic [ICW-1:0] idle_cnt_reg;
  logic [TCW-1:0] start_cnt_reg;

  logic [3:0] col_a [2];
  logic [3:0] row_a [2];
  logic [3:0] ocol_a [2];
  logic [3:0] orow_a [2];
  logic       st_a [2];
  logic [9:0] px_x [2];
  logic [8:0] px_y [2];
  logic [9:0] px_ox [2];
  logic [8:0] px_oy [2];
  logic [1:0] in_range;
  logic       gnt;

  assign col_a[0]  = req0_col;
  assign row_a[0]  = req0_row;
  assign ocol_a[0] = req0_old_col;
  assign orow_a[0] = req0_old_row;
  assign st_a[0]   = req0_state;
  assign col_a[1]  = req1_col;
  assign row_a[1]  = req1_row;
  assign ocol_a[1] = req1_old_col;
  assign orow_a[1] = req1_old_row;
  assign st_a[1]   = req1_state;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign in_range[gi] = (col_a[gi] <= 4'(GRID_MAX)) && (row_a[gi] <= 4'(GRID_MAX)) &&
                            (ocol_a[gi] <= 4'(GRID_MAX)) && (orow_a[gi] <= 4'(GRID_MAX));
      assign px_x[gi]  = 10'(X0) + 10'(col_a[gi]) * 10'(PITCH);
      assign px_y[gi]  = 9'(Y0) + 9'(row_a[gi]) * 9'(PITCH);
      assign px_ox[gi] = 10'(X0) + 10'(ocol_a[gi]) * 10'(PITCH);
      assign px_oy[gi] = 9'(Y0) + 9'(orow_a[gi]) * 9'(PITCH);
    end
  endgenerate

  // On contention the requester that did not win last time goes first.
  assign gnt = (req0 && req1) ? ~rr_reg : req1;

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      fsm_reg       <= S_INIT_BUSY;
      rr_reg        <= 1'b0;
      idle_cnt_reg  <= '0;
      start_cnt_reg <= '0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      draw_enable   <= 1'b0;
      X             <= 10'(X0);
      Y             <= 9'(Y0);
      OLD_X         <= 10'(X0);
      OLD_Y         <= 9'(Y0);
      state         <= 1'b0;
      ready         <= 1'b0;
      err           <= 1'b0;
`ifdef DRAW_STATS_EN
      draw_count    <= '0;
      drop_count    <= '0;
`endif
    end else begin
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      draw_enable <= 1'b0;
      case (fsm_reg)
        S_INIT_BUSY: begin
          if (drawing) begin
            fsm_reg      <= S_INIT_IDLE;
            idle_cnt_reg <= '0;
          end
        end
        // The display dips drawing for one cycle between box and cursor, so wait for a run of idles.
        S_INIT_IDLE, S_WAIT_DONE: begin
          if (drawing) begin
            idle_cnt_reg <= '0;
          end else if (idle_cnt_reg == ICW'(IDLE_CYCLES - 1)) begin
            idle_cnt_reg <= '0;
            fsm_reg      <= S_READY;
            ready        <= 1'b1;
`ifdef DRAW_STATS_EN
            if (fsm_reg == S_WAIT_DONE && draw_count != '1) draw_count <= draw_count + 16'd1;
`endif
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
        S_READY: begin
          if ((req0 || req1) && !ack0 && !ack1) begin
            if (req0 && req1) rr_reg <= gnt;
            ack0 <= ~gnt;
            ack1 <= gnt;
            if (!in_range[gnt]) begin
              err <= 1'b1;
`ifdef DRAW_STATS_EN
              if (drop_count != '1) drop_count <= drop_count + 8'd1;
`endif
            end else begin
              X       <= px_x[gnt];
              Y       <= px_y[gnt];
              OLD_X   <= px_ox[gnt];
              OLD_Y   <= px_oy[gnt];
              state   <= st_a[gnt];
              ready   <= 1'b0;
              fsm_reg <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          draw_enable   <= 1'b1;
          start_cnt_reg <= '0;
          fsm_reg       <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (drawing) begin
            idle_cnt_reg <= '0;
            fsm_reg      <= S_WAIT_DONE;
          end else if (start_cnt_reg == TCW'(START_TIMEOUT - 1)) begin
            err     <= 1'b1;
            ready   <= 1'b1;
            fsm_reg <= S_READY;
`ifdef DRAW_STATS_EN
            if (drop_count != '1) drop_count <= drop_count + 8'd1;
`endif
          end else begin
            start_cnt_reg <= start_cnt_reg + 1'b1;
          end
        end
        default: fsm_reg <= S_INIT_BUSY;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Scoreboard bench for vga_draw_scheduler: stimulus queues expected acks/draws, a monitor checks them.
module tb_vga_draw_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       nReset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] req0_col = '0, req0_row = '0, req0_old_col = '0, req0_old_row = '0;
  logic [3:0] req1_col = '0, req1_row = '0, req1_old_col = '0, req1_old_row = '0;
  logic       req0_state = 1'b0, req1_state = 1'b0;
  logic       ack0, ack1, drawing, draw_enable, state, ready, err;
  logic [9:0] X, OLD_X;
  logic [8:0] Y, OLD_Y;
`ifdef DRAW_STATS_EN
  logic [15:0] draw_count;
  logic [7:0]  drop_count;
`endif

  logic model_en = 1'b0, model_drawing = 1'b0, man_drawing = 1'b0;
  int   mseq = 0;
  assign drawing = model_en ? model_drawing : man_drawing;

  always #5 CLOCK_50 = ~CLOCK_50;

  vga_draw_scheduler dut (
    .CLOCK_50(CLOCK_50), .nReset(nReset),
    .req0(req0), .req0_col(req0_col), .req0_row(req0_row), .req0_old_col(req0_old_col),
    .req0_old_row(req0_old_row), .req0_state(req0_state), .ack0(ack0),
    .req1(req1), .req1_col(req1_col), .req1_row(req1_row), .req1_old_col(req1_old_col),
    .req1_old_row(req1_old_row), .req1_state(req1_state), .ack1(ack1),
    .drawing(drawing), .draw_enable(draw_enable),
    .X(X), .Y(Y), .OLD_X(OLD_X), .OLD_Y(OLD_Y), .state(state), .ready(ready), .err(err)
`ifdef DRAW_STATS_EN
    , .draw_count(draw_count), .drop_count(drop_count)
`endif
  );

  // Display model: box draw, one-cycle dip, cursor draw, then idle.
  always @(negedge CLOCK_50) begin
    if (!model_en) mseq = 0;
    else if (draw_enable) mseq = 1;
    else if (mseq != 0 && mseq < 10) mseq = mseq + 1;
    else mseq = 0;
    model_drawing = (mseq >= 1 && mseq <= 4) || (mseq >= 6 && mseq <= 9);
  end

  typedef struct {
    logic       is_draw;
    logic       who;
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] ox;
    logic [8:0] oy;
    logic       st;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  function automatic void push_ack(input logic who);
    exp_t e;
    e = '{1'b0, who, 10'd0, 9'd0, 10'd0, 9'd0, 1'b0};
    exp_q.push_back(e);
  endfunction

  function automatic void push_draw(input logic [9:0] x, input logic [8:0] y,
                                    input logic [9:0] ox, input logic [8:0] oy, input logic st);
    exp_t e;
    e = '{1'b1, 1'b0, x, y, ox, oy, st};
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLOCK_50);
      if (nReset) begin
        if (ack0 || ack1) begin
          chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b, want none", ack0, ack1);
          end else begin
            e = exp_q.pop_front();
            chk("ack_event_kind", 32'(draw_enable), 32'(e.is_draw));
            chk("ack_who", 32'(ack1), 32'(e.who));
          end
        end
        if (draw_enable) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_draw: got draw_enable=1 X=%0d Y=%0d, want none", X, Y);
          end else begin
            e = exp_q.pop_front();
            chk("draw_event_kind", 32'(draw_enable), 32'(e.is_draw));
            chk("draw_X", 32'(X), 32'(e.x));
            chk("draw_Y", 32'(Y), 32'(e.y));
            chk("draw_OLD_X", 32'(OLD_X), 32'(e.ox));
            chk("draw_OLD_Y", 32'(OLD_Y), 32'(e.oy));
            chk("draw_state", 32'(state), 32'(e.st));
          end
        end
      end
    end
  endtask

  task automatic set_req(input logic who, input logic [3:0] c, input logic [3:0] r,
                         input logic [3:0] oc, input logic [3:0] orw, input logic s);
    if (who) begin
      req1_col = c; req1_row = r; req1_old_col = oc; req1_old_row = orw; req1_state = s; req1 = 1'b1;
    end else begin
      req0_col = c; req0_row = r; req0_old_col = oc; req0_old_row = orw; req0_state = s; req0 = 1'b1;
    end
  endtask

  task automatic wait_ack(input logic who, input string name);
    int n = 0;
    while (((who ? ack1 : ack0) !== 1'b1) && n < 30) begin tick(); n++; end
    chk(name, 32'(who ? ack1 : ack0), 32'd1);
  endtask

  task automatic wait_ready(input string name, input int limit);
    int n = 0;
    while (ready !== 1'b1 && n < limit) begin tick(); n++; end
    chk(name, 32'(ready), 32'd1);
  endtask

  task automatic do_reset();
    model_en = 1'b0; man_drawing = 1'b0;
    nReset = 1'b0;
    tick(); tick();
    nReset = 1'b1;
  endtask

  task automatic do_init();
    man_drawing = 1'b1;
    repeat (5) tick();
    man_drawing = 1'b0;
    wait_ready("init_ready", 20);
  endtask

  task automatic stimulus();
    int rises, acks;
    logic prev;

    // 1: reset state and power-up fill tracking
    tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_X", 32'(X), 32'd214);
    chk("rst_Y", 32'(Y), 32'd32);
    chk("rst_OLD_X", 32'(OLD_X), 32'd214);
    chk("rst_OLD_Y", 32'(OLD_Y), 32'd32);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_draw_enable", 32'(draw_enable), 32'd0);
    tick();
    nReset = 1'b1;
    repeat (20) tick();
    chk("t1_idle_no_ready", 32'(ready), 32'd0);
    man_drawing = 1'b1;
    repeat (5000) tick();
    chk("t1_fill_no_ready", 32'(ready), 32'd0);
    man_drawing = 1'b0;
    tick();
    chk("t1_fall_plus1", 32'(ready), 32'd0);
    tick();
    chk("t1_fall_plus2", 32'(ready), 32'd0);
    tick();
    chk("t1_fall_plus3", 32'(ready), 32'd1);

    // 2: single request, draw with a one-cycle dip in drawing
    model_en = 1'b1;
    push_ack(1'b0);
    push_draw(10'd280, 9'd131, 10'd247, 9'd131, 1'b1);
    set_req(1'b0, 4'd2, 4'd3, 4'd1, 4'd3, 1'b1);
    wait_ack(1'b0, "t2_ack0");
    req0 = 1'b0;
    chk("t2_ready_low_on_grant", 32'(ready), 32'd0);
    tick();
    chk("t2_draw_enable_latency", 32'(draw_enable), 32'd1);
    rises = 0; prev = ready;
    repeat (40) begin
      tick();
      if (ready && !prev) rises++;
      prev = ready;
    end
    chk("t2_single_ready_return", 32'(rises), 32'd1);
    chk("t2_ready_end", 32'(ready), 32'd1);
    chk("t2_err", 32'(err), 32'd0);
`ifdef DRAW_STATS_EN
    chk("t2_draw_count", 32'(draw_count), 32'd1);
`endif

    // 3: contention from reset, both held -> 1,0,1,0
    do_reset();
    do_init();
    model_en = 1'b1;
    push_ack(1'b1); push_draw(10'd577, 9'd395, 10'd544, 9'd395, 1'b1);
    push_ack(1'b0); push_draw(10'd214, 9'd32, 10'd214, 9'd32, 1'b0);
    push_ack(1'b1); push_draw(10'd577, 9'd395, 10'd544, 9'd395, 1'b1);
    push_ack(1'b0); push_draw(10'd214, 9'd32, 10'd214, 9'd32, 1'b0);
    set_req(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    set_req(1'b1, 4'd11, 4'd11, 4'd10, 4'd11, 1'b1);
    acks = 0;
    for (int n = 0; n < 200 && acks < 4; n++) begin
      tick();
      if (ack0 || ack1) acks++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("t3_ack_count", 32'(acks), 32'd4);
    wait_ready("t3_ready", 40);

    // 4: out-of-range request is acked and dropped
    chk("t4_err_before", 32'(err), 32'd0);
    push_ack(1'b1);
    set_req(1'b1, 4'd12, 4'd0, 4'd0, 4'd0, 1'b0);
    wait_ack(1'b1, "t4_ack1");
    req1 = 1'b0;
    chk("t4_err_set", 32'(err), 32'd1);
    chk("t4_ready_kept", 32'(ready), 32'd1);
    repeat (6) tick();
    chk("t4_ready_after", 32'(ready), 32'd1);

    // 5: start timeout, then a normal request
    do_reset();
    do_init();
    push_ack(1'b0);
    push_draw(10'd379, 9'd230, 10'd379, 9'd197, 1'b0);
    set_req(1'b0, 4'd5, 4'd6, 4'd5, 4'd5, 1'b0);
    wait_ack(1'b0, "t5_ack0");
    req0 = 1'b0;
    repeat (8) tick();
    chk("t5_no_timeout_yet", 32'(ready), 32'd0);
    chk("t5_err_not_yet", 32'(err), 32'd0);
    tick();
    chk("t5_timeout_ready", 32'(ready), 32'd1);
    chk("t5_timeout_err", 32'(err), 32'd1);
    model_en = 1'b1;
    push_ack(1'b1);
    push_draw(10'd247, 9'd65, 10'd214, 9'd32, 1'b1);
    set_req(1'b1, 4'd1, 4'd1, 4'd0, 4'd0, 1'b1);
    wait_ack(1'b1, "t5_next_ack1");
    req1 = 1'b0;
    wait_ready("t5_next_ready", 40);

    // 6: reset during WAIT_DONE, init repeats before next grant
    do_reset();
    do_init();
    model_en = 1'b1;
    push_ack(1'b0);
    push_draw(10'd313, 9'd164, 10'd313, 9'd131, 1'b1);
    set_req(1'b0, 4'd3, 4'd4, 4'd3, 4'd3, 1'b1);
    wait_ack(1'b0, "t6_ack0");
    req0 = 1'b0;
    repeat (4) tick();
    nReset = 1'b0;
    model_en = 1'b0;
    #1;
    chk("t6_rst_X", 32'(X), 32'd214);
    chk("t6_rst_Y", 32'(Y), 32'd32);
    chk("t6_rst_OLD_X", 32'(OLD_X), 32'd214);
    chk("t6_rst_OLD_Y", 32'(OLD_Y), 32'd32);
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_ready", 32'(ready), 32'd0);
    tick(); tick();
    nReset = 1'b1;
    set_req(1'b0, 4'd3, 4'd4, 4'd3, 4'd3, 1'b1);
    acks = 0;
    repeat (10) begin tick(); if (ack0) acks++; end
    chk("t6_no_grant_before_init", 32'(acks), 32'd0);
    chk("t6_not_ready", 32'(ready), 32'd0);
    push_ack(1'b0);
    push_draw(10'd313, 9'd164, 10'd313, 9'd131, 1'b1);
    man_drawing = 1'b1;
    repeat (5) tick();
    man_drawing = 1'b0;
    model_en = 1'b1;
    wait_ack(1'b0, "t6_regrant");
    req0 = 1'b0;
    wait_ready("t6_ready", 40);

    repeat (5) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
